// File: rtl/sr_cmd_sequencer.sv
// Debounced set/reset command front-end driving an enable-gated SR latch with setup/pulse/hold sequencing.
// Optional: define SR_RESET_PRIORITY_EN to turn a simultaneous set+reset press into a reset command.
module sr_cmd_sequencer #(
  parameter int DEB_CYCLES   = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_req,
  input  logic             reset_req,
  output logic             S,
  output logic             R,
  output logic             enable,
  output logic             busy,
  output logic [CNT_W-1:0] cmd_count
);

  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int PULSE_W = $clog2(PULSE_CYCLES + 1);

  localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEB_CYCLES);
  localparam logic [DEB_W-1:0]   REL_MAX   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PULSE_W-1:0] PULSE_MAX = PULSE_W'(PULSE_CYCLES);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] DEBOUNCE     = 3'd1;
  localparam logic [2:0] SETUP        = 3'd2;
  localparam logic [2:0] PULSE        = 3'd3;
  localparam logic [2:0] HOLD         = 3'd4;
  localparam logic [2:0] WAIT_RELEASE = 3'd5;

  logic             set_meta_q, set_sync_q, rst_meta_q, rst_sync_q;
  logic [2:0]       state_q, state_d;
  logic [1:0]       cap_q, cap_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic             s_q, s_d, r_q, r_d, en_q, en_d, busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pair;

  assign pair = {set_sync_q, rst_sync_q};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cap_d       = cap_q;
    deb_cnt_d   = deb_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    s_d         = s_q;
    r_d         = r_q;
    en_d        = en_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        s_d  = 1'b0;
        r_d  = 1'b0;
        en_d = 1'b0;
        if (pair != 2'b00) begin
          cap_d     = pair;
          deb_cnt_d = DEB_W'(1);
          state_d   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (pair == cap_q) begin
          if (deb_cnt_q == DEB_MAX) begin
            deb_cnt_d = '0;
            case (cap_q)
              2'b10: begin state_d = SETUP; s_d = 1'b1; end
              2'b01: begin state_d = SETUP; r_d = 1'b1; end
`ifdef SR_RESET_PRIORITY_EN
              2'b11: begin state_d = SETUP; r_d = 1'b1; end
`else
              2'b11: state_d = WAIT_RELEASE;
`endif
              default: state_d = IDLE;
            endcase
          end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
          end
        end else if (pair == 2'b00) begin
          deb_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          cap_d     = pair;
          deb_cnt_d = DEB_W'(1);
        end
      end
      SETUP: begin
        en_d        = 1'b1;
        pulse_cnt_d = PULSE_W'(1);
        cnt_d       = cnt_q + CNT_W'(1);
        state_d     = PULSE;
      end
      PULSE: begin
        if (pulse_cnt_q == PULSE_MAX) begin
          en_d        = 1'b0;
          pulse_cnt_d = '0;
          state_d     = HOLD;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
        end
      end
      HOLD: begin
        s_d     = 1'b0;
        r_d     = 1'b0;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        // Any activity restarts the release window, so a held button yields one command.
        if (pair != 2'b00) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == REL_MAX) begin
          deb_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: begin
        s_d     = 1'b0;
        r_d     = 1'b0;
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_meta_q  <= 1'b0;
      set_sync_q  <= 1'b0;
      rst_meta_q  <= 1'b0;
      rst_sync_q  <= 1'b0;
      state_q     <= IDLE;
      cap_q       <= 2'b00;
      deb_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      set_meta_q  <= set_req;
      set_sync_q  <= set_meta_q;
      rst_meta_q  <= reset_req;
      rst_sync_q  <= rst_meta_q;
      state_q     <= state_d;
      cap_q       <= cap_d;
      deb_cnt_q   <= deb_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      s_q         <= s_d;
      r_q         <= r_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign S         = s_q;
  assign R         = r_q;
  assign enable    = en_q;
  assign busy      = busy_q;
  assign cmd_count = cnt_q;

endmodule

// File: doc/sr_cmd_sequencer.md
Name: sr_cmd_sequencer

Overview:
Clocked command front-end that sits directly upstream of the team's enable-gated SR latch. It takes two raw, bouncy request lines (set, reset), synchronises and debounces them, and resolves conflicting requests. It then drives the latch's S, R and enable inputs with a clean, glitch-free setup/pulse/hold sequence. It never presents S=R=1 to the latch, and it never changes S/R while enable is high.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronised cycles required to accept a press or a release (>=1)
PULSE_CYCLES, 2, number of cycles enable is held high per command (>=1)
CNT_W, 8, width of issued-command counter

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
set_req  input  1  raw set request, asynchronous to clk, may bounce
reset_req  input  1  raw reset request, asynchronous to clk, may bounce
S  output  1  latch set input (registered)
R  output  1  latch reset input (registered)
enable  output  1  latch enable (registered)
busy  output  1  high whenever state != IDLE (registered)
cmd_count  output  CNT_W  number of commands issued, wraps modulo 2^CNT_W

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE; S=R=enable=busy=0; cmd_count=0; both 2-flop synchronisers=0; debounce and pulse counters=0.
- Reset mid-operation: aborts immediately, including mid-pulse. A request still held after reset deasserts is treated as a new press and is debounced from scratch.
- Synchroniser: 2 flops per request line; pair P={set_s,reset_s}.
- States: IDLE, DEBOUNCE, SETUP, PULSE, HOLD, WAIT_RELEASE.
- IDLE: S=R=enable=0. If P!=00, capture P into cap, set cnt=1, go to DEBOUNCE.
- DEBOUNCE:
  - If P==cap: increment cnt. When cnt reaches DEB_CYCLES, accept cap.
  - If P!=cap and P==00: go to IDLE.
  - If P!=cap and P!=00: recapture P, set cnt=1.
  - Accept with cap=10: go to SETUP with S=1. Accept with cap=01: go to SETUP with R=1. Accept with cap=11: see Optional Feature.
- SETUP (1 cycle): S/R valid, enable=0. Go to PULSE.
- PULSE: enable=1 for exactly PULSE_CYCLES cycles, S/R held. Increment cmd_count on PULSE entry. Go to HOLD.
- HOLD (1 cycle): enable=0, S/R still held. Go to WAIT_RELEASE with S=R=0.
- WAIT_RELEASE: requires P==00 for DEB_CYCLES consecutive cycles, then IDLE. Any nonzero P resets that count. No new command can issue until release, so holding a button produces exactly one command.
- Input changes during SETUP/PULSE/HOLD are ignored; the sequence always completes.
- Latency, with edge 0 the first edge sampling a raw request high and the request held stable:
  - set_s=1 after edge 1; DEBOUNCE entered at edge 2.
  - S=1 from edge 2+DEB_CYCLES.
  - enable=1 from edge 3+DEB_CYCLES for PULSE_CYCLES cycles.
  - S=0 from edge 4+DEB_CYCLES+PULSE_CYCLES.
- Invariants: S&R==0 always. S/R never change in a cycle where enable=1. busy=0 only in IDLE.
- cmd_count wraps from 2^CNT_W-1 to 0 with no flag.

Optional Feature:
Macro SR_RESET_PRIORITY_EN.
- Defined: accepted cap=11 issues a reset command (R=1) through SETUP/PULSE/HOLD; cmd_count increments.
- Undefined: accepted cap=11 issues nothing and goes straight to WAIT_RELEASE; S=R=enable stay 0 and cmd_count is unchanged.

Test Plan:
- rst=1 two cycles, then set_req=1 held (DEB_CYCLES=4, PULSE_CYCLES=2) -> S rises at edge 6, enable high at edges 7-8 and low from edge 9, S low from edge 10, cmd_count=1, busy high from edge 2 until 4 cycles after release.
- set_req toggles every 2 cycles for 20 cycles, then 0 -> S, R, enable never assert; cmd_count=0; state back to IDLE.
- set_req held for 100 cycles -> exactly one command; cmd_count=1; busy stays 1 until 4 cycles after release.
- set_req and reset_req both held -> with SR_RESET_PRIORITY_EN: one R pulse, cmd_count=1. Without it: no S/R/enable activity, cmd_count=0. S&R==0 checked every cycle.
- rst asserted during PULSE (second enable cycle) -> next edge: enable=S=R=busy=0, cmd_count=0. Request still held -> reissued after a full rebounce.
- 256 alternating set/reset presses with CNT_W=8 -> cmd_count wraps to 0. Alternating S and R commands observed, each with a 1-cycle setup and 1-cycle hold around enable.
